miner_csr_bank: RTL and testbench

Parametrised Avalon-MM slave register bank and mining controller that sits between the host bus and an array of `NUM_CORES` SHA-256 miner cores. It holds the target and message words, starts all cores on partitioned nonce ranges, and arbitrates their found nonces into a result FIFO. It exposes a run/status state machine to the host. It supersedes the single-core register front end and keeps that block's address map and status codes at default parameters.

---
 rtl/miner_csr_pkg.sv | 42 ++++
 rtl/miner_result_fifo.sv | 53 +++++
 rtl/miner_csr_bank.sv | 199 +++++++++++++++++++
 tb/tb_miner_csr_bank.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/miner_csr_pkg.sv
// Shared constants and types for the miner CSR bank: address map, CONTROL codes,
// controller state encoding and STATUS codes.
package miner_csr_pkg;

    // Fixed low addresses; the rest of the map follows the target/message word counts.
    localparam int unsigned AddrStatus     = 0;
    localparam int unsigned AddrControl    = 1;
    localparam int unsigned AddrTargetBase = 2;

    function automatic int unsigned addr_result(input int unsigned target_words);
        return AddrTargetBase + target_words;
    endfunction

    function automatic int unsigned addr_msg_base(input int unsigned target_words);
        return AddrTargetBase + target_words + 1;
    endfunction

    function automatic int unsigned addr_count(input int unsigned target_words,
                                               input int unsigned msg_words);
        return AddrTargetBase + target_words + 1 + msg_words;
    endfunction

    localparam logic [31:0] CtrlLoadTarget = 32'd1;
    localparam logic [31:0] CtrlStart      = 32'd2;
    localparam logic [31:0] CtrlAbort      = 32'd4;
    localparam logic [31:0] CtrlPop        = 32'd8;

    typedef enum logic [2:0] {
        StIdle,
        StTgtLoaded,
        StMining,
        StFound,
        StExhausted
    } state_t;

    localparam logic [31:0] StatusIdle      = 32'd0;
    localparam logic [31:0] StatusTgtLoaded = 32'd1;
    localparam logic [31:0] StatusMining    = 32'd2;
    localparam logic [31:0] StatusFound     = 32'd3;
    localparam logic [31:0] StatusExhausted = 32'd4;

endpackage

// File: rtl/miner_result_fifo.sv
// Synchronous result FIFO with flush; push when full and pop when empty are dropped.
module miner_result_fifo #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 32,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
        end
    end

endmodule

// File: rtl/miner_csr_bank.sv
// Avalon-MM register bank and run controller for an array of SHA-256 miner cores.
// Define MINER_CSR_MULTI_RESULT_EN to keep mining after a find and queue further nonces.
module miner_csr_bank
    import miner_csr_pkg::*;
#(
    parameter int unsigned NUM_CORES    = 4,
    parameter int unsigned TARGET_WORDS = 8,
    parameter int unsigned MSG_WORDS    = 19,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned ADDR_W       = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         slaveAddr,
    input  logic [31:0]               slaveWriteData,
    input  logic                      slaveWrite,
    input  logic                      slaveRead,
    input  logic                      slaveChipSelect,
    output logic [31:0]               slaveReadData,
    output logic [TARGET_WORDS*32-1:0] targetOut,
    output logic [MSG_WORDS*32-1:0]   msgOut,
    output logic                      coreStart,
    output logic                      coreAbort,
    output logic [NUM_CORES*32-1:0]   coreNonceBase,
    input  logic [NUM_CORES-1:0]      coreFound,
    input  logic [NUM_CORES*32-1:0]   coreNonce,
    output logic [NUM_CORES-1:0]      coreAck,
    input  logic [NUM_CORES-1:0]      coreDone
);

`ifdef MINER_CSR_MULTI_RESULT_EN
    localparam bit MultiResult = 1'b1;
`else
    localparam bit MultiResult = 1'b0;
`endif

    localparam int unsigned CntW        = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned AddrResult  = addr_result(TARGET_WORDS);
    localparam int unsigned AddrMsgBase = addr_msg_base(TARGET_WORDS);
    localparam int unsigned AddrCount   = addr_count(TARGET_WORDS, MSG_WORDS);

    state_t                    state_q, state_d;
    logic                      start_q, start_d, abort_q, abort_d;
    logic [NUM_CORES-1:0]      ack_q, found_avail, grant;
    logic [31:0]               grant_nonce, rd_data, status;
    logic [TARGET_WORDS*32-1:0] target_q;
    logic [MSG_WORDS*32-1:0]   msg_q;
    logic [31:0]               rd_data_q;
    int unsigned               addr;
    logic wr_en, rd_en, ctrl_wr, regs_wr, found_any;
    logic cmd_load, cmd_start, cmd_abort, cmd_pop;
    logic push_ok, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [31:0]               fifo_head;
    logic [CntW-1:0]           fifo_count;

    assign addr      = 32'(slaveAddr);
    assign wr_en     = slaveWrite && slaveChipSelect;
    assign rd_en     = slaveRead && slaveChipSelect;
    assign ctrl_wr   = wr_en && (addr == AddrControl);
    assign regs_wr   = wr_en && (state_q != StMining);
    assign cmd_load  = ctrl_wr && (slaveWriteData == CtrlLoadTarget);
    assign cmd_start = ctrl_wr && (slaveWriteData == CtrlStart);
    assign cmd_abort = ctrl_wr && (slaveWriteData == CtrlAbort);
    assign cmd_pop   = ctrl_wr && (slaveWriteData == CtrlPop);

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_nonce_base
        assign coreNonceBase[32*i +: 32] = 32'((64'(i) << 32) / NUM_CORES);
    end

    // A core still sees its found flag in the cycle its ack is out; don't grant it twice.
    assign found_avail = coreFound & ~ack_q;

    always_comb begin
        grant       = '0;
        grant_nonce = '0;
        found_any   = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (found_avail[i] && !found_any) begin
                grant[i]    = 1'b1;
                grant_nonce = coreNonce[32*i +: 32];
                found_any   = 1'b1;
            end
        end
    end

    assign push_ok = (state_q == StMining) && !fifo_full && (|found_avail) && !cmd_abort;

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        abort_d    = 1'b0;
        fifo_flush = 1'b0;
        fifo_pop   = cmd_pop;
        if (cmd_abort) begin
            state_d    = StIdle;
            abort_d    = 1'b1;
            fifo_flush = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: if (cmd_load) state_d = StTgtLoaded;
                StTgtLoaded, StFound, StExhausted: begin
                    if (cmd_start) begin
                        state_d    = StMining;
                        start_d    = 1'b1;
                        fifo_flush = 1'b1;
                    end else if (!MultiResult && state_q == StFound && cmd_pop) begin
                        state_d = StTgtLoaded;
                    end
                end
                StMining: begin
                    if (!MultiResult && push_ok) begin
                        state_d = StFound;
                        abort_d = 1'b1;
                    end else if ((&coreDone) && !(|coreFound)) begin
                        state_d = StExhausted;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        if (!fifo_empty) begin
            status = StatusFound;
        end else begin
            unique case (state_q)
                StTgtLoaded: status = StatusTgtLoaded;
                StMining:    status = StatusMining;
                StFound:     status = StatusFound;
                StExhausted: status = StatusExhausted;
                default:     status = StatusIdle;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr == AddrStatus) rd_data = status;
        if (addr == AddrResult && !fifo_empty) rd_data = fifo_head;
        if (addr == AddrCount) rd_data = 32'(fifo_count);
        for (int j = 0; j < TARGET_WORDS; j++) begin
            if (addr == AddrTargetBase + 32'(j)) rd_data = target_q[32*j +: 32];
        end
        for (int j = 0; j < MSG_WORDS; j++) begin
            if (addr == AddrMsgBase + 32'(j)) rd_data = msg_q[32*j +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            ack_q     <= '0;
            target_q  <= '0;
            msg_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            abort_q <= abort_d;
            ack_q   <= push_ok ? grant : '0;
            if (rd_en) rd_data_q <= rd_data;
            for (int j = 0; j < TARGET_WORDS; j++) begin
                if (regs_wr && addr == AddrTargetBase + 32'(j)) begin
                    target_q[32*j +: 32] <= slaveWriteData;
                end
            end
            for (int j = 0; j < MSG_WORDS; j++) begin
                if (regs_wr && addr == AddrMsgBase + 32'(j)) msg_q[32*j +: 32] <= slaveWriteData;
            end
        end
    end

    miner_result_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data (grant_nonce),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign slaveReadData = rd_data_q;
    assign targetOut     = target_q;
    assign msgOut        = msg_q;
    assign coreStart     = start_q;
    assign coreAbort     = abort_q;
    assign coreAck       = ack_q;

endmodule

// File: tb/tb_miner_csr_bank.sv
// Directed self-checking bench for miner_csr_bank; follows MINER_CSR_MULTI_RESULT_EN if defined.
module tb_miner_csr_bank;

`ifdef MINER_CSR_MULTI_RESULT_EN
    localparam bit Multi = 1'b1;
`else
    localparam bit Multi = 1'b0;
`endif

    localparam int NC = 4;
    localparam int TW = 8;
    localparam int MW = 19;
    localparam int FD = 8;
    localparam int AW = 5;

    logic              clk, rst;
    logic [AW-1:0]     slaveAddr;
    logic [31:0]       slaveWriteData, slaveReadData;
    logic              slaveWrite, slaveRead, slaveChipSelect;
    logic [TW*32-1:0]  targetOut;
    logic [MW*32-1:0]  msgOut;
    logic              coreStart, coreAbort;
    logic [NC*32-1:0]  coreNonceBase, coreNonce;
    logic [NC-1:0]     coreFound, coreAck, coreDone;
    logic [NC-1:0]     req, clr;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] d;

    miner_csr_bank #(
        .NUM_CORES    (NC),
        .TARGET_WORDS (TW),
        .MSG_WORDS    (MW),
        .FIFO_DEPTH   (FD),
        .ADDR_W       (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .slaveAddr       (slaveAddr),
        .slaveWriteData  (slaveWriteData),
        .slaveWrite      (slaveWrite),
        .slaveRead       (slaveRead),
        .slaveChipSelect (slaveChipSelect),
        .slaveReadData   (slaveReadData),
        .targetOut       (targetOut),
        .msgOut          (msgOut),
        .coreStart       (coreStart),
        .coreAbort       (coreAbort),
        .coreNonceBase   (coreNonceBase),
        .coreFound       (coreFound),
        .coreNonce       (coreNonce),
        .coreAck         (coreAck),
        .coreDone        (coreDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: found rises the edge after req, holds until acked or cleared.
    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (rst || clr[i] || coreAck[i]) coreFound[i] <= 1'b0;
            else if (req[i]) coreFound[i] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_write(input int a, input logic [31:0] v);
        slaveChipSelect = 1'b1;
        slaveWrite      = 1'b1;
        slaveAddr       = AW'(a);
        slaveWriteData  = v;
        @(negedge clk);
        slaveChipSelect = 1'b0;
        slaveWrite      = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [31:0] v);
        slaveChipSelect = 1'b1;
        slaveRead       = 1'b1;
        slaveAddr       = AW'(a);
        @(negedge clk);
        slaveChipSelect = 1'b0;
        slaveRead       = 1'b0;
        v = slaveReadData;
    endtask

    initial begin
        rst = 1'b1; slaveChipSelect = 1'b0; slaveWrite = 1'b0; slaveRead = 1'b0;
        slaveAddr = '0; slaveWriteData = '0; req = '0; clr = '0; coreDone = '0;
        coreNonce = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_start", 32'(coreStart), 32'd0);
        chk("rst_abort", 32'(coreAbort), 32'd0);
        chk("rst_ack", 32'(coreAck), 32'd0);
        chk("rst_rdata", slaveReadData, 32'd0);
        bus_read(0, d);  chk("rst_status", d, 32'd0);
        bus_read(30, d); chk("rst_count", d, 32'd0);
        chk("nonce_base0", coreNonceBase[31:0], 32'h0000_0000);
        chk("nonce_base1", coreNonceBase[63:32], 32'h4000_0000);
        chk("nonce_base3", coreNonceBase[127:96], 32'hC000_0000);

        bus_write(1, 32'd2);
        chk("idle_start_no_pulse", 32'(coreStart), 32'd0);
        bus_read(0, d); chk("idle_start_status", d, 32'd0);

        bus_write(1, 32'd1);
        bus_read(0, d); chk("load_status", d, 32'd1);
        for (int j = 0; j < TW; j++) bus_write(2 + j, 32'h1000_0000 + 32'(j) * 32'h0101_0101);
        bus_read(9, d); chk("target_rd9", d, 32'h1707_0707);
        bus_read(5, d); chk("target_rd5", d, 32'h1303_0303);
        bus_read(2, d); chk("target_rd2", d, 32'h1000_0000);
        chk("target_out_msw", targetOut[255:224], 32'h1707_0707);
        bus_write(29, 32'hDEAD_BEEF);
        chk("msg_out_first", msgOut[607:576], 32'hDEAD_BEEF);
        bus_write(11, 32'h1234_5678);
        bus_read(11, d); chk("msg_rd11", d, 32'h1234_5678);

        bus_write(1, 32'd2);
        chk("start_pulse", 32'(coreStart), 32'd1);
        tick();
        chk("start_pulse_end", 32'(coreStart), 32'd0);
        bus_read(0, d); chk("mining_status", d, 32'd2);
        bus_write(2, 32'hFFFF_FFFF);
        bus_read(2, d); chk("mining_wr_ignored", d, 32'h1000_0000);
        bus_read(10, d); chk("result_empty", d, 32'd0);

        // Single find from core 2
        coreNonce[95:64] = 32'h4000_0123;
        req[2] = 1'b1; tick(); req = '0;
        tick();
        chk("find2_ack", 32'(coreAck), 32'b0100);
        chk("find2_abort", 32'(coreAbort), Multi ? 32'd0 : 32'd1);
        bus_read(10, d); chk("find2_result", d, 32'h4000_0123);
        chk("find2_ack_once", 32'(coreAck), 32'd0);
        chk("find2_abort_once", 32'(coreAbort), 32'd0);
        bus_read(0, d);  chk("find2_status", d, 32'd3);
        bus_read(30, d); chk("find2_count", d, 32'd1);
        bus_write(1, 32'd8);
        bus_read(30, d); chk("pop_count", d, 32'd0);
        bus_read(0, d);  chk("pop_status", d, Multi ? 32'd2 : 32'd1);
        bus_write(1, 32'd8);
        bus_read(30, d); chk("pop_empty_count", d, 32'd0);

        // ABORT in the same cycle as a pending find: no ack, no push
        bus_write(1, 32'd4);
        chk("abort_pulse", 32'(coreAbort), 32'd1);
        bus_write(1, 32'd1);
        bus_write(1, 32'd2);
        req[1] = 1'b1; tick(); req = '0;
        bus_write(1, 32'd4);
        chk("abort_beats_push_ack", 32'(coreAck), 32'd0);
        chk("abort_beats_push_pulse", 32'(coreAbort), 32'd1);
        tick();
        chk("abort_idle_no_ack", 32'(coreAck), 32'd0);
        bus_read(30, d); chk("abort_count", d, 32'd0);
        bus_read(0, d);  chk("abort_status", d, 32'd0);
        clr[1] = 1'b1; tick(); clr = '0;

        // Cores 0 and 3 find together
        bus_write(1, 32'd1);
        bus_write(1, 32'd2);
        coreNonce[31:0]   = 32'h0000_0ABC;
        coreNonce[127:96] = 32'hC000_0DEF;
        req = 4'b1001; tick(); req = '0;
        tick();
        chk("dual_ack_first", 32'(coreAck), 32'b0001);
        chk("dual_abort", 32'(coreAbort), Multi ? 32'd0 : 32'd1);
        tick();
        chk("dual_ack_second", 32'(coreAck), Multi ? 32'b1000 : 32'b0000);
        tick();
        chk("dual_ack_idle", 32'(coreAck), 32'd0);
        bus_read(30, d); chk("dual_count", d, Multi ? 32'd2 : 32'd1);
        bus_read(10, d); chk("dual_head", d, 32'h0000_0ABC);
        clr = 4'b1000; tick(); clr = '0;

        // Exhaustion
        bus_write(1, 32'd4);
        bus_write(1, 32'd1);
        bus_write(1, 32'd2);
        coreDone = 4'hF;
        tick(); tick();
        bus_read(0, d); chk("exhausted_status", d, 32'd4);
        bus_write(1, 32'd4);
        chk("exhausted_abort_pulse", 32'(coreAbort), 32'd1);
        coreDone = '0;
        bus_read(0, d);  chk("exh_abort_status", d, 32'd0);
        bus_read(30, d); chk("exh_abort_count", d, 32'd0);
        bus_read(31, d); chk("unmapped_rd", d, 32'd0);

`ifdef MINER_CSR_MULTI_RESULT_EN
        // Fill the FIFO, then one more find must wait for a POP
        bus_write(1, 32'd1);
        bus_write(1, 32'd2);
        for (int k = 0; k < FD; k++) begin
            coreNonce[32*(k%NC) +: 32] = 32'(k + 100);
            req[k%NC] = 1'b1; tick(); req = '0;
            tick(); tick();
        end
        bus_read(30, d); chk("full_count", d, 32'(FD));
        coreNonce[31:0] = 32'h0000_0999;
        req[0] = 1'b1; tick(); req = '0;
        repeat (3) tick();
        chk("full_held_ack", 32'(coreAck), 32'd0);
        chk("full_held_found", 32'(coreFound[0]), 32'd1);
        bus_read(30, d); chk("full_count_held", d, 32'(FD));
        bus_write(1, 32'd8);
        chk("pop_full_no_ack_yet", 32'(coreAck), 32'd0);
        tick();
        chk("pop_full_ack", 32'(coreAck), 32'b0001);
        tick();
        bus_read(30, d); chk("pop_full_refill", d, 32'(FD));
        bus_read(10, d); chk("pop_full_head", d, 32'd101);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
